// File: rtl/mp_axi4_memory.sv
// Shared synchronous word RAM for NUM_PORTS requesters: round-robin grant, byte strobes,
// READ_LATENCY-deep read pipeline and out-of-range read error flag.
module mp_axi4_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int ADDR_WIDTH   = $clog2(MEMORY_DEPTH),
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_PORTS-1:0]              mem_en,
  input  logic [NUM_PORTS-1:0]              mem_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   mem_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   mem_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [NUM_PORTS-1:0]              mem_ready,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int STAGES = READ_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_PORTS-1:0][NB-1:0]         wstrb_v;

  assign addr_v  = mem_addr;
  assign wdata_v = mem_wdata;
  assign wstrb_v = mem_wstrb;

  logic [PW-1:0]         ptr, ptr_nxt, gnt_idx;
  logic [PW:0]           j;
  logic [NUM_PORTS-1:0]  gnt;
  logic                  found, acc, wr_acc, rd_acc, in_range;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // Rotating priority search starting at ptr, wrapping past the top port.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = {1'b0, ptr} + (PW+1)'(i);
      if (j >= (PW+1)'(NUM_PORTS)) j = j - (PW+1)'(NUM_PORTS);
      if (!found && mem_en[j[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = j[PW-1:0];
      end
    end
    if (found && !ARESET) gnt[gnt_idx] = 1'b1;
  end

  assign mem_ready = gnt;
  assign acc       = found & ~ARESET;
  assign wr_acc    = acc & mem_we[gnt_idx];
  assign rd_acc    = acc & ~mem_we[gnt_idx];
  assign sel_addr  = addr_v[gnt_idx];
  assign in_range  = {1'b0, sel_addr} < DEPTH;
  assign ptr_nxt   = (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;

  logic [DATA_WIDTH-1:0] ram [MEMORY_DEPTH];

  // RAM contents survive reset; out-of-range writes are silently dropped.
  always_ff @(posedge ACLK) begin
    if (wr_acc && in_range)
      for (int b = 0; b < NB; b++)
        if (wstrb_v[gnt_idx][b]) ram[sel_addr][b*8 +: 8] <= wdata_v[gnt_idx][b*8 +: 8];
  end

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0]                 err_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0] dat_pipe;
  logic [STAGES:0][PW-1:0]         id_pipe;

  // Payload only advances alongside a valid, so the last stage holds its
  // final response while the pipeline is idle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ptr      <= '0;
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      if (acc) ptr <= ptr_nxt;
      vld_pipe[0] <= rd_acc;
      if (rd_acc) begin
        dat_pipe[0] <= in_range ? ram[sel_addr] : '0;
        err_pipe[0] <= ~in_range;
        id_pipe[0]  <= gnt_idx;
      end
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          dat_pipe[s] <= dat_pipe[s-1];
          err_pipe[s] <= err_pipe[s-1];
          id_pipe[s]  <= id_pipe[s-1];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (vld_pipe[STAGES]) rsp_valid[id_pipe[STAGES]] = 1'b1;
  end

  assign rsp_rdata = dat_pipe[STAGES];
  assign rsp_err   = err_pipe[STAGES];

endmodule

// File: tb/tb_mp_axi4_memory.sv
// Directed bench for mp_axi4_memory (4 ports, depth 1000, read latency 2) with a
// queue scoreboard drained by a negedge monitor.
module tb_mp_axi4_memory;
  localparam int DW = 32, DEPTH = 1000, AW = 10, NP = 4, RL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]         mem_en, mem_we, mem_ready, rsp_valid;
  logic [NP-1:0][AW-1:0] addr_v;
  logic [NP-1:0][DW-1:0] wdata_v;
  logic [NP-1:0][3:0]    wstrb_v;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;

  mp_axi4_memory #(
    .DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .NUM_PORTS(NP), .READ_LATENCY(RL)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(addr_v),
    .mem_wdata(wdata_v), .mem_wstrb(wstrb_v),
    .mem_ready(mem_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int port; logic [31:0] data; logic err; int due;} exp_t;
  exp_t sbq[$];
  int gcnt[NP];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    if (rsp_valid !== '0) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp valid=%b data=%h cyc=%0d", rsp_valid, rsp_rdata, cyc);
      end else begin
        e = sbq.pop_front();
        if (rsp_valid !== (4'b1 << e.port) || rsp_rdata !== e.data || rsp_err !== e.err || cyc != e.due) begin
          errors++;
          $display("FAIL rsp got valid=%b data=%h err=%b cyc=%0d want valid=%b data=%h err=%b cyc=%0d",
                   rsp_valid, rsp_rdata, rsp_err, cyc, 4'b1 << e.port, e.data, e.err, e.due);
        end
      end
    end else if (sbq.size() != 0 && cyc >= sbq[0].due) begin
      checks++;
      errors++;
      e = sbq.pop_front();
      $display("FAIL rsp_missing port=%0d data=%h due=%0d cyc=%0d", e.port, e.data, e.due, cyc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic req(int p, logic we, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s,
                     logic push, logic [31:0] ed, logic ee);
    int  acyc;
    bit  ok;
    mem_en[p] = 1'b1; mem_we[p] = we; addr_v[p] = a; wdata_v[p] = d; wstrb_v[p] = s;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      if (mem_ready[p]) begin
        ok   = 1'b1;
        acyc = cyc + 1;
        if (!we && push) sbq.push_back('{p, ed, ee, acyc + RL - 1});
      end
      @(posedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout port=%0d", p);
    end
    #1 mem_en[p] = 1'b0;
  endtask

  task automatic wr(int p, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s);
    req(p, 1'b1, a, d, s, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(int p, logic [AW-1:0] a, logic [31:0] ed, logic ee);
    req(p, 1'b0, a, '0, '0, 1'b1, ed, ee);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sbq.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_en = '1; mem_we = '0; addr_v = '0; wdata_v = '0; wstrb_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(mem_ready), 64'd0);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_err",   64'(rsp_err),   64'd0);

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Fairness: every port requests a no-op write for 8 cycles.
    mem_we = '1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("grant%0d", i), 64'(mem_ready), 64'(4'b1 << (i % 4)));
      for (int p = 0; p < NP; p++) if (mem_ready[p]) gcnt[p]++;
      @(posedge clk);
    end
    #1 mem_en = '0;
    for (int p = 0; p < NP; p++) chk($sformatf("grant_count%0d", p), 64'(gcnt[p]), 64'd2);

    wr(0, 10'd5, 32'hDEADBEEF, 4'hF);
    rd(0, 10'd5, 32'hDEADBEEF, 1'b0);

    wr(2, 10'd7, 32'hFFFFFFFF, 4'hF);
    wr(2, 10'd7, 32'h12345678, 4'b0101);
    rd(3, 10'd7, 32'hFF34FF78, 1'b0);
    wr(1, 10'd7, 32'h00000000, 4'b0000);
    rd(1, 10'd7, 32'hFF34FF78, 1'b0);
    drain();

    for (int i = 0; i < 4; i++) wr(1, AW'(i), 32'h100 + i, 4'hF);
    for (int i = 0; i < 4; i++) rd(1, AW'(i), 32'h100 + i, 1'b0);
    drain();
    repeat (2) @(posedge clk);
    #1 chk("hold_rdata", 64'(rsp_rdata), 64'h103);

    // Two ports contending; scoreboard order follows grant order.
    fork
      rd(2, 10'd5, 32'hDEADBEEF, 1'b0);
      rd(3, 10'd0, 32'h00000100, 1'b0);
    join
    drain();

    wr(0, 10'd508, 32'h0BADF00D, 4'hF);
    rd(0, 10'd1000, 32'h0, 1'b1);
    wr(3, 10'd1020, 32'hAAAA5555, 4'hF);
    rd(2, 10'd508, 32'h0BADF00D, 1'b0);
    rd(1, 10'd5, 32'hDEADBEEF, 1'b0);
    rd(3, 10'd1020, 32'h0, 1'b1);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("hold_err", 64'(rsp_err), 64'd1);

    // Read accepted, then reset lands while it is in flight.
    req(0, 1'b0, 10'd5, '0, '0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_err",   64'(rsp_err),   64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd0);
    rst = 1'b0;
    mem_we = '1; wstrb_v = '0; mem_en = '1;
    #1 chk("ptr_after_reset", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #1 mem_en = '0;
    repeat (6) @(posedge clk);
    #1 chk("queue_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
